multi_flex_counter: RTL and testbench
=====================================

# multi_flex_counter

Parametrised, multi-channel successor to the team's single flex counter: NUM_CHANNELS independent counters of NUM_CNT_BITS each, sharing one clock and reset.

Each channel adds the following to the original counter:
- up/down direction;
- wrap or saturate behaviour at the terminal value;
- synchronous parallel load;
- a registered wrap pulse and a sticky overflow status.

The block feeds timers, pixel/line counters and event counters that previously instantiated several flex counters side by side.

## Interface
- NUM_CHANNELS, 4, number of independent counter channels (≥1)
- NUM_CNT_BITS, 4, width of each channel's count (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- clear  in  NUM_CHANNELS  per-channel synchronous clear
- load  in  NUM_CHANNELS  per-channel synchronous load of load_val slice
- load_val  in  NUM_CHANNELS*NUM_CNT_BITS  load values; channel i at [i*NUM_CNT_BITS +: NUM_CNT_BITS]
- count_enable  in  NUM_CHANNELS  per-channel step enable
- count_down  in  NUM_CHANNELS  1 = decrement, 0 = increment (sampled with count_enable)
- sat_mode  in  NUM_CHANNELS  1 = saturate at terminal, 0 = wrap
- rollover_val  in  NUM_CHANNELS*NUM_CNT_BITS  per-channel terminal value, same slicing
- status_clr  in  NUM_CHANNELS  per-channel clear of overflow_sticky
- count_out  out  NUM_CHANNELS*NUM_CNT_BITS  registered counts, same slicing
- rollover_flag  out  NUM_CHANNELS  registered; channel sits on its terminal value
- wrap_pulse  out  NUM_CHANNELS  registered single-cycle pulse on a wrap
- overflow_sticky  out  NUM_CHANNELS  registered sticky overflow/wrap indication
- any_rollover  out  1  combinational OR of rollover_flag

## Operation
- Channels are fully independent; the description below is per channel i, with R = rollover_val slice and C = count_out slice.
- Priority per cycle is clear > load > count_enable > hold.
- **clear:**
  - C←0, rollover_flag←0, wrap_pulse←0.
  - overflow_sticky←0.
- **load:**
  - C←load_val slice, rollover_flag←0, wrap_pulse←0.
  - overflow_sticky unchanged.
- **Up step** (count_enable=1, count_down=0):
  - If C < R: C←C+1.
  - If C ≥ R (terminal; includes C>R after a load or an R change):
    - wrap mode: C←0 and the step is a wrap.
    - saturate mode: C held and the step is a saturation.
- **Down step** (count_enable=1, count_down=1):
  - If C > 0: C←C−1.
  - If C = 0 (terminal):
    - wrap mode: C←R and the step is a wrap.
    - saturate mode: C held and the step is a saturation.
- **rollover_flag:**
  - After any enabled step, it is 1 iff the new C equals that step's terminal value (R for up, 0 for down).
  - It is held when no step occurs.
- **wrap_pulse:** 1 for exactly the cycle after a wrap step; 0 otherwise.
- **overflow_sticky:**
  - Set by any wrap or saturation step.
  - Cleared by status_clr or clear.
  - Set wins over status_clr in the same cycle.
- **R = 0:**
  - Up steps keep C at 0 (terminal), with rollover_flag=1.
  - In wrap mode, every up step wraps.
- Arithmetic is unsigned, NUM_CNT_BITS wide; no step ever produces a value outside 0..max(R, loaded value).
- Changing count_down or sat_mode mid-count takes effect on the next enabled step; no state is lost.

## Timing
- Reset values: count_out=0, rollover_flag=0, wrap_pulse=0, overflow_sticky=0, so any_rollover=0.
- Reset is asynchronous and active-high: asserting rst mid-count forces all registers to reset values immediately, independent of clk.
- Latency is one cycle: inputs sampled on a rising clk edge appear on count_out, rollover_flag, wrap_pulse and overflow_sticky after that edge.
- any_rollover follows rollover_flag combinationally, with zero added latency.
- clear, load, count_enable and status_clr are level-sampled each cycle. There is no handshake, and a continuously asserted enable steps every cycle.
- Simultaneous clear+load+enable on one channel: clear only. Simultaneous load+enable: load only.

## Test plan
- **Reset and basic up count:**
  - Stimulus: NUM_CNT_BITS=4, R=5, wrap, enable held.
  - Required: count 1,2,3,4,5,0,1; rollover_flag=1 only while C=5; wrap_pulse=1 for the single cycle C=0 appears; overflow_sticky=1 from then on.
- **Saturate and status clear:**
  - Stimulus: R=3, sat_mode=1, up, enable held; then status_clr pulse with enable low.
  - Required: C=3 held; rollover_flag stays 1; wrap_pulse never asserts; overflow_sticky set on the first held step and cleared by status_clr.
- **Down wrap:**
  - Stimulus: load 2, R=9, count_down=1, wrap.
  - Required: C=2,1,0,9,8; rollover_flag=1 at 0 only; wrap_pulse with C=9.
- **Load beyond R and priority:**
  - Stimulus: R=4, load 12, then one up step in wrap mode; same cycle as a later step, assert clear+load+enable.
  - Required: C=12, then 0 with wrap_pulse; the simultaneous cycle gives C=0 and overflow_sticky=0.
- **Channel independence:**
  - Stimulus: 4 channels with different R, direction and mode driven concurrently.
  - Required: each matches a per-channel model; any_rollover equals the OR of the flags every cycle.
- **Asynchronous reset mid-operation:**
  - Stimulus: assert rst between clock edges during counting.
  - Required: all outputs reach 0 before the next edge and stay 0 while rst=1; counting resumes from 0 after deassertion.

Source files
------------

// File: rtl/multi_flex_counter.sv
// multi_flex_counter
//   NUM_CHANNELS independent up/down counters of NUM_CNT_BITS each, with
//   per-channel wrap/saturate behaviour, synchronous clear and parallel
//   load, a registered wrap pulse and a sticky overflow status.
//
// Ports (channel i occupies slice [i*NUM_CNT_BITS +: NUM_CNT_BITS] of the
// wide vectors, and bit i of the narrow ones):
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   clear           synchronous clear (count, flags and sticky status)
//   load            synchronous load of load_val
//   load_val        load values
//   count_enable    step enable
//   count_down      1 = decrement, 0 = increment
//   sat_mode        1 = saturate at terminal, 0 = wrap
//   rollover_val    terminal value R for up counting
//   status_clr      clears overflow_sticky
//   count_out       registered counts
//   rollover_flag   registered: channel sits on its terminal value
//   wrap_pulse      registered single-cycle pulse following a wrap step
//   overflow_sticky registered sticky wrap/saturation indication
//   any_rollover    combinational OR of rollover_flag
module multi_flex_counter #(
    parameter int NUM_CHANNELS = 4,
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CHANNELS-1:0]              clear,
    input  logic [NUM_CHANNELS-1:0]              load,
    input  logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CHANNELS-1:0]              count_enable,
    input  logic [NUM_CHANNELS-1:0]              count_down,
    input  logic [NUM_CHANNELS-1:0]              sat_mode,
    input  logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] rollover_val,
    input  logic [NUM_CHANNELS-1:0]              status_clr,
    output logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] count_out,
    output logic [NUM_CHANNELS-1:0]              rollover_flag,
    output logic [NUM_CHANNELS-1:0]              wrap_pulse,
    output logic [NUM_CHANNELS-1:0]              overflow_sticky,
    output logic                                 any_rollover
);

    localparam int W = NUM_CNT_BITS;
    localparam logic [W-1:0] ONE = W'(1);

    assign any_rollover = |rollover_flag;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic [W-1:0] cnt;
        logic         flag;
        logic         pulse;
        logic         sticky;

        logic [W-1:0] r;
        logic [W-1:0] step_cnt;
        logic         step_flag;
        logic         step_wrap;
        logic         step_sat;

        assign r = rollover_val[i*W +: W];

        // Result of an enabled step. C > R (after a load or an R change)
        // counts as terminal for up steps, so the count never leaves
        // 0..max(R, loaded value).
        always_comb begin
            step_cnt  = cnt;
            step_wrap = 1'b0;
            step_sat  = 1'b0;
            if (count_down[i]) begin
                if (cnt != '0) begin
                    step_cnt = cnt - ONE;
                end else if (sat_mode[i]) begin
                    step_sat = 1'b1;
                end else begin
                    step_cnt  = r;
                    step_wrap = 1'b1;
                end
                step_flag = (step_cnt == '0);
            end else begin
                if (cnt < r) begin
                    step_cnt = cnt + ONE;
                end else if (sat_mode[i]) begin
                    step_sat = 1'b1;
                end else begin
                    step_cnt  = '0;
                    step_wrap = 1'b1;
                end
                step_flag = (step_cnt == r);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt    <= '0;
                flag   <= 1'b0;
                pulse  <= 1'b0;
                sticky <= 1'b0;
            end else if (clear[i]) begin
                cnt    <= '0;
                flag   <= 1'b0;
                pulse  <= 1'b0;
                sticky <= 1'b0;
            end else if (load[i]) begin
                cnt    <= load_val[i*W +: W];
                flag   <= 1'b0;
                pulse  <= 1'b0;
                sticky <= sticky & ~status_clr[i];
            end else if (count_enable[i]) begin
                cnt    <= step_cnt;
                flag   <= step_flag;
                pulse  <= step_wrap;
                // A new overflow event outranks a simultaneous status clear.
                sticky <= step_wrap | step_sat | (sticky & ~status_clr[i]);
            end else begin
                pulse  <= 1'b0;
                sticky <= sticky & ~status_clr[i];
            end
        end

        assign count_out[i*W +: W] = cnt;
        assign rollover_flag[i]    = flag;
        assign wrap_pulse[i]       = pulse;
        assign overflow_sticky[i]  = sticky;
    end

endmodule

// File: tb/tb_multi_flex_counter.sv
// Testbench for multi_flex_counter: directed table for channel 0, an
// asynchronous reset sequence, and randomized multi-channel traffic
// checked against a behavioural model.
module tb_multi_flex_counter;

    localparam int NCH = 4;
    localparam int W   = 4;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [NCH-1:0]   clear, load, count_enable, count_down, sat_mode, status_clr;
    logic [NCH*W-1:0] load_val, rollover_val;
    logic [NCH*W-1:0] count_out;
    logic [NCH-1:0]   rollover_flag, wrap_pulse, overflow_sticky;
    logic             any_rollover;

    multi_flex_counter #(.NUM_CHANNELS(NCH), .NUM_CNT_BITS(W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .count_enable(count_enable), .count_down(count_down), .sat_mode(sat_mode),
        .rollover_val(rollover_val), .status_clr(status_clr),
        .count_out(count_out), .rollover_flag(rollover_flag),
        .wrap_pulse(wrap_pulse), .overflow_sticky(overflow_sticky),
        .any_rollover(any_rollover)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt [NCH];
    bit m_rf  [NCH];
    bit m_wp  [NCH];
    bit m_os  [NCH];

    function automatic int sl(input logic [NCH*W-1:0] v, input int ch);
        return int'(v[ch*W +: W]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_rf[c] = 0; m_wp[c] = 0; m_os[c] = 0;
        end
    endtask

    // Applies one clock edge worth of the rules to every channel.
    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            int  r, target;
            bit  can_move, event_hit;
            r = sl(rollover_val, c);
            event_hit = 0;
            m_wp[c] = 0;
            if (clear[c]) begin
                m_cnt[c] = 0; m_rf[c] = 0; m_os[c] = 0;
            end else if (load[c]) begin
                m_cnt[c] = sl(load_val, c); m_rf[c] = 0;
                if (status_clr[c]) m_os[c] = 0;
            end else if (count_enable[c]) begin
                target   = count_down[c] ? 0 : r;
                can_move = count_down[c] ? (m_cnt[c] > 0) : (m_cnt[c] < r);
                if (can_move) begin
                    m_cnt[c] = count_down[c] ? m_cnt[c] - 1 : m_cnt[c] + 1;
                end else begin
                    event_hit = 1;
                    if (!sat_mode[c]) begin
                        m_cnt[c] = count_down[c] ? r : 0;
                        m_wp[c]  = 1;
                    end
                end
                m_rf[c] = (m_cnt[c] == target);
                if (event_hit) m_os[c] = 1;
                else if (status_clr[c]) m_os[c] = 0;
            end else begin
                if (status_clr[c]) m_os[c] = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        bit any_m;
        any_m = 0;
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("%s ch%0d count", tag, c), sl(count_out, c), m_cnt[c]);
            chk($sformatf("%s ch%0d rflag", tag, c), int'(rollover_flag[c]), int'(m_rf[c]));
            chk($sformatf("%s ch%0d wrap", tag, c), int'(wrap_pulse[c]), int'(m_wp[c]));
            chk($sformatf("%s ch%0d sticky", tag, c), int'(overflow_sticky[c]), int'(m_os[c]));
            any_m |= m_rf[c];
        end
        chk({tag, " any_rollover"}, int'(any_rollover), int'(any_m));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " count_out"}, int'(count_out), 0);
        chk({tag, " rollover_flag"}, int'(rollover_flag), 0);
        chk({tag, " wrap_pulse"}, int'(wrap_pulse), 0);
        chk({tag, " overflow_sticky"}, int'(overflow_sticky), 0);
        chk({tag, " any_rollover"}, int'(any_rollover), 0);
    endtask

    task automatic idle_inputs();
        clear = '0; load = '0; count_enable = '0; count_down = '0;
        sat_mode = '0; status_clr = '0; load_val = '0; rollover_val = '0;
    endtask

    // ---------------- directed table (channel 0) ----------------
    typedef struct {
        bit cl, ld; int lv; bit en, dn, sat; int r; bit sc;
        int ecnt; bit erf, ewp, eos;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(bit cl, bit ld, int lv, bit en, bit dn, bit sat, int r, bit sc,
                                int ecnt, bit erf, bit ewp, bit eos);
        vec_t v;
        v.cl = cl; v.ld = ld; v.lv = lv; v.en = en; v.dn = dn; v.sat = sat; v.r = r; v.sc = sc;
        v.ecnt = ecnt; v.erf = erf; v.ewp = ewp; v.eos = eos;
        return v;
    endfunction

    initial begin
        idle_inputs();
        rst = 1'b1;
        #12;
        check_all_zero("reset");
        rst = 1'b0;

        //                cl ld lv en dn sat r sc   cnt rf wp os
        // basic up count, R=5, wrap
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5, 0,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5, 0,   2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5, 0,   3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5, 0,   4, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5, 0,   5, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5, 0,   0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5, 0,   1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5, 0,   0, 0, 0, 0));
        // saturate at R=3, then status clear with enable low
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 3, 0,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 3, 0,   2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 3, 0,   3, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 3, 0,   3, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 3, 0,   3, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 1,   3, 1, 0, 0));
        // down wrap from load 2, R=9
        vecs.push_back(mk(0, 1, 2, 0, 1, 0, 9, 0,   2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 9, 0,   1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 9, 0,   0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 9, 0,   9, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 9, 0,   8, 0, 0, 1));
        // load beyond R and priority
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4, 0,   0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 12, 0, 0, 0, 4, 0,  12, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 4, 0,   0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 4, 0,   1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 7, 1, 0, 0, 4, 0,   0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3, 1, 0, 0, 4, 0,   3, 0, 0, 0));
        // R = 0: every up step wraps in wrap mode, holds in saturate mode
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,   0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,   0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1,   0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 1));

        @(negedge clk);
        foreach (vecs[k]) begin
            clear[0] = vecs[k].cl; load[0] = vecs[k].ld;
            load_val[W-1:0] = W'(vecs[k].lv);
            count_enable[0] = vecs[k].en; count_down[0] = vecs[k].dn;
            sat_mode[0] = vecs[k].sat; rollover_val[W-1:0] = W'(vecs[k].r);
            status_clr[0] = vecs[k].sc;
            @(posedge clk); #1;
            chk($sformatf("vec%0d count", k), sl(count_out, 0), vecs[k].ecnt);
            chk($sformatf("vec%0d rflag", k), int'(rollover_flag[0]), int'(vecs[k].erf));
            chk($sformatf("vec%0d wrap", k), int'(wrap_pulse[0]), int'(vecs[k].ewp));
            chk($sformatf("vec%0d sticky", k), int'(overflow_sticky[0]), int'(vecs[k].eos));
            chk($sformatf("vec%0d any", k), int'(any_rollover), int'(vecs[k].erf));
        end

        // ---------------- randomized multi-channel traffic ----------------
        idle_inputs();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < NCH; c++)
            rollover_val[c*W +: W] = W'($urandom_range(MAXV, 0));

        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                clear[c]        = ($urandom_range(39, 0) == 0);
                load[c]         = ($urandom_range(19, 0) == 0);
                load_val[c*W +: W] = W'($urandom_range(MAXV, 0));
                count_enable[c] = ($urandom_range(3, 0) != 0);
                if ($urandom_range(15, 0) == 0) count_down[c] = ~count_down[c];
                if ($urandom_range(15, 0) == 0) sat_mode[c] = ~sat_mode[c];
                if ($urandom_range(31, 0) == 0)
                    rollover_val[c*W +: W] = W'($urandom_range(MAXV, 0));
                status_clr[c]   = ($urandom_range(7, 0) == 0);
            end
            @(posedge clk);
            model_step();
            #1;
            check_model($sformatf("rnd%0d", cyc));

            // asynchronous reset between edges, held across one edge
            if (cyc == 300) begin
                #2 rst = 1'b1;
                #1 check_all_zero("async rst");
                @(posedge clk); #1;
                check_all_zero("rst held");
                rst = 1'b0;
                model_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound in case the clock or a wait ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
